base_arb_rr: RTL
================

BASE_ARB_RR -- requirements
Module: base_arb_rr

Interface
REQ-001 SHALL have parameter ways, default 2, number of requesters; legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, [0:ways-1], per-requester beat valid.
REQ-005 SHALL have port last, input, [0:ways-1], per-requester final-beat flag; qualified by req.
REQ-006 SHALL have port o_r, input, 1, downstream ready.
REQ-007 SHALL have port gnt, output, [0:ways-1], one-hot or zero grant.
REQ-008 SHALL have port o_v, output, 1, downstream valid = |(gnt & req).
REQ-009 SHALL have port o_last, output, 1, = |(gnt & last).
REQ-010 SHALL have port ack, output, [0:ways-1], = gnt when (o_v & o_r), else zero; marks the beat taken.
REQ-011 SHALL have port locked, output, 1, high while in state HOLD.

Function
REQ-012 SHALL define transfer = o_v & o_r, and packet end = transfer & o_last.
REQ-013 SHALL keep a thermometer mask register msk[0:ways-1]; after packet end on way g, msk[i]=1 exactly for i<g.
REQ-014 SHALL, in ARB, pick from req & msk when nonzero, else from req; highest index wins (index 0 lowest priority).
REQ-015 SHALL drive gnt combinationally from the pick in ARB; gnt = 0 and o_v = 0 when req = 0.
REQ-016 SHALL keep a grant register gnt_q loaded with gnt whenever ARB moves to HOLD; in HOLD gnt = gnt_q regardless of req.
REQ-017 SHALL move ARB -> HOLD when o_v & ~o_r (stall) or when a transfer occurs with o_last = 0 (packet lock).
REQ-018 SHALL stay in ARB on packet end, updating msk the same cycle.
REQ-019 SHALL move HOLD -> ARB only on packet end, updating msk; any other HOLD cycle holds state, gnt_q and msk.
REQ-020 SHALL, in HOLD with req[granted] low, drive o_v = 0, keep gnt, and never re-arbitrate (requester protocol violation tolerated, not recovered).
REQ-021 SHALL leave msk unchanged on transfers with o_last = 0.
REQ-022 SHALL have zero-cycle latency from req to gnt/o_v in ARB; no beat is dropped or duplicated.
REQ-023 SHALL guarantee each continuously requesting way a packet end within ways-1 other packets.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-packet, force state ARB, msk = 0, gnt_q = 0 asynchronously.
REQ-025 SHALL, during and immediately after reset, give gnt = pick of req with msk = 0, locked = 0, and ack = 0 while o_r = 0.

Structure
REQ-026 SHALL place the state enum (ARB, HOLD) in shared package base_arb_pkg; no other shared constants.
REQ-027 SHALL instantiate base_prienc_lp (ways wide) twice, once for masked and once for unmasked requests; no other sub-modules.

Verification (ways=4, vectors written req[0..3])
REQ-028 SHALL check: reset, req=1111, last=1111, o_r=1 for 5 cycles -> ack on way 3,2,1,0,3; locked stays 0.
REQ-029 SHALL check: req=0101, way 3 last=0 for 2 beats then 1, o_r=1 -> gnt=0001 for 3 cycles, locked=1 on beats 2-3, then gnt=0100.
REQ-030 SHALL check: req=0011, o_r=0 for 3 cycles then 1 -> gnt=0001 held all 4 cycles, ack=0001 only in cycle 4, next gnt=0010.
REQ-031 SHALL check: reset pulsed mid-packet in HOLD on way 2 -> locked=0, msk=0 immediately; with req=1110 next gnt=0010.
REQ-032 SHALL check: req=0000 for 3 cycles, o_r=1 -> gnt=0000, o_v=0, ack=0000, msk unchanged.
REQ-033 SHALL check: locked on way 1, req[1] drops for 2 cycles while req=1001 -> o_v=0, gnt=0100 held, no ack to ways 0 or 3.

Source files
------------

// File: rtl/base_arb_pkg.sv
// Shared types for the round-robin packet arbiter.
//   state_e : arbiter FSM state (ARB = free to pick, HOLD = grant frozen)
package base_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : base_arb_pkg

// File: rtl/base_prienc_lp.sv
// Fixed-priority encoder: one-hot pick of the highest set request index;
// index 0 has the lowest priority.
// Ports:
//   req_i [0:ways-1] : request vector
//   gnt_o [0:ways-1] : one-hot grant, zero when req_i is zero
module base_prienc_lp #(
    parameter int unsigned ways = 2
) (
    input  logic [0:ways-1] req_i,
    output logic [0:ways-1] gnt_o
);

    // Scan from the top index down; the first set bit wins.
    always_comb begin : pick_highest
        logic found;
        found = 1'b0;
        gnt_o = '0;
        for (int i = int'(ways) - 1; i >= 0; i--) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule : base_prienc_lp

// File: rtl/base_arb_rr.sv
// Round-robin packet arbiter. A thermometer mask rotates priority after each
// packet end; the grant is frozen (HOLD) across stalls and multi-beat packets.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   req  [0:ways-1]  : per-requester beat valid
//   last [0:ways-1]  : per-requester final-beat flag
//   o_r              : downstream ready
//   gnt  [0:ways-1]  : one-hot or zero grant (combinational)
//   o_v, o_last      : downstream valid / last of the granted requester
//   ack  [0:ways-1]  : grant qualified by an accepted beat
//   locked           : high while the grant is frozen
module base_arb_rr
    import base_arb_pkg::*;
#(
    parameter int unsigned ways = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:ways-1] req,
    input  logic [0:ways-1] last,
    input  logic            o_r,
    output logic [0:ways-1] gnt,
    output logic            o_v,
    output logic            o_last,
    output logic [0:ways-1] ack,
    output logic            locked
);

    state_e          state_q, state_d;
    logic [0:ways-1] msk_q, msk_d;
    logic [0:ways-1] gnt_q, gnt_d;

    logic [0:ways-1] pick_msk, pick_all, pick;
    logic [0:ways-1] therm;
    logic            xfer, pkt_end;

    base_prienc_lp #(.ways(ways)) u_enc_msk (
        .req_i (req & msk_q),
        .gnt_o (pick_msk)
    );

    base_prienc_lp #(.ways(ways)) u_enc_all (
        .req_i (req),
        .gnt_o (pick_all)
    );

    // Prefer requesters below the last winner; wrap to the full set otherwise.
    assign pick = (|(req & msk_q)) ? pick_msk : pick_all;

    // Outputs derived from whichever grant is live this cycle.
    assign gnt     = (state_q == HOLD) ? gnt_q : pick;
    assign o_v     = |(gnt & req);
    assign o_last  = |(gnt & last);
    assign xfer    = o_v & o_r;
    assign pkt_end = xfer & o_last;
    assign ack     = xfer ? gnt : '0;
    assign locked  = (state_q == HOLD);

    // Thermometer of the live grant: ones strictly below the granted index.
    always_comb begin : therm_from_gnt
        logic seen;
        seen  = 1'b0;
        therm = '0;
        for (int i = int'(ways) - 1; i >= 0; i--) begin
            therm[i] = seen;
            seen     = seen | gnt[i];
        end
    end

    // Next-state: lock on stall or mid-packet beat, release on packet end.
    always_comb begin : next_state
        state_d = state_q;
        msk_d   = msk_q;
        gnt_d   = gnt_q;
        if (pkt_end) begin
            msk_d = therm;
        end
        unique case (state_q)
            ARB: begin
                if ((o_v && !o_r) || (xfer && !o_last)) begin
                    state_d = HOLD;
                    gnt_d   = gnt;
                end
            end
            HOLD: begin
                if (pkt_end) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            state_q <= ARB;
            msk_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            msk_q   <= msk_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule : base_arb_rr
